regfile_wb_arbiter: RTL and testbench

// - Owns the single write port of the 32x32 register file; shares it between two writeback

---
 rtl/regfile_wb_arbiter_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_if.sv | 48 ++++
 rtl/regfile_wb_arbiter_rr.sv | 35 +++
 rtl/regfile_wb_arbiter.sv | 97 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
// Source encoding doubles as the round-robin pointer value.
package regfile_pkg;

   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 5;
   localparam int NUM_REGS = 1 << ADDR_W;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } wb_src_e;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of issue-side scoreboard, writeback request and register-file write signals.
// The slave modport is the arbiter; master is everything around it.
interface regfile_wb_arbiter_if;
   import regfile_pkg::*;

   logic              alloc_valid_i;
   logic [ADDR_W-1:0] alloc_addr_i;
   logic [ADDR_W-1:0] rs_addr_i;
   logic [ADDR_W-1:0] rt_addr_i;
   logic              rs_busy_o;
   logic              rt_busy_o;
   logic              rd_busy_o;

   logic              alu_valid_i;
   logic [ADDR_W-1:0] alu_addr_i;
   logic [DATA_W-1:0] alu_data_i;
   logic              alu_ready_o;
   logic              mem_valid_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [DATA_W-1:0] mem_data_i;
   logic              mem_ready_o;

   logic              RegWrite_o;
   logic [ADDR_W-1:0] RDaddr_o;
   logic [DATA_W-1:0] RDdata_o;
   logic              err_o;

   modport slave (
      input  alloc_valid_i, alloc_addr_i, rs_addr_i, rt_addr_i,
      output rs_busy_o, rt_busy_o, rd_busy_o,
      input  alu_valid_i, alu_addr_i, alu_data_i,
      output alu_ready_o,
      input  mem_valid_i, mem_addr_i, mem_data_i,
      output mem_ready_o,
      output RegWrite_o, RDaddr_o, RDdata_o, err_o
   );

   modport master (
      output alloc_valid_i, alloc_addr_i, rs_addr_i, rt_addr_i,
      input  rs_busy_o, rt_busy_o, rd_busy_o,
      output alu_valid_i, alu_addr_i, alu_data_i,
      input  alu_ready_o,
      output mem_valid_i, mem_addr_i, mem_data_i,
      input  mem_ready_o,
      input  RegWrite_o, RDaddr_o, RDdata_o, err_o
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr.sv
// Two-way round-robin arbiter: combinational grant, pointer moves to the
// source that was not granted after every grant.
module rr_arbiter2
   import regfile_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   wb_src_e ptr_q, ptr_d;

   always_comb begin
      gnt_o = req_i;
      if (req_i == 2'b11) begin
         gnt_o = (ptr_q == SRC_MEM) ? 2'b10 : 2'b01;
      end
      ptr_d = ptr_q;
      if (gnt_o[0]) begin
         ptr_d = SRC_MEM;
      end else if (gnt_o[1]) begin
         ptr_d = SRC_ALU;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_q <= SRC_ALU;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin ALU/MEM writeback, registered write
// port, busy scoreboard for issue hazard checks and a sticky protocol error flag.
module regfile_wb_arbiter
   import regfile_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   regfile_wb_arbiter_if.slave bus
);

   logic [1:0]          req, gnt;
   logic                accept;
   wb_req_t             win;

   logic                regwrite_q, regwrite_d;
   logic [ADDR_W-1:0]   rdaddr_q, rdaddr_d;
   logic [DATA_W-1:0]   rddata_q, rddata_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                err_q, err_d;
   logic                alloc_err, wr_err;

   // Requests are masked during reset so nothing is acknowledged and then dropped.
   assign req = {bus.mem_valid_i, bus.alu_valid_i} & {2{~rst_i}};

   rr_arbiter2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (req),
      .gnt_o (gnt)
   );

   always_comb begin
      win.addr = bus.alu_addr_i;
      win.data = bus.alu_data_i;
      if (gnt[SRC_MEM]) begin
         win.addr = bus.mem_addr_i;
         win.data = bus.mem_data_i;
      end
   end

   assign accept          = |gnt;
   assign bus.alu_ready_o = gnt[SRC_ALU];
   assign bus.mem_ready_o = gnt[SRC_MEM];

   assign bus.rs_busy_o = busy_q[bus.rs_addr_i];
   assign bus.rt_busy_o = busy_q[bus.rt_addr_i];
   assign bus.rd_busy_o = busy_q[bus.alloc_addr_i];

   // Re-allocating a register that retires on this very edge is legal back-to-back reuse.
   assign alloc_err = bus.alloc_valid_i && bus.rd_busy_o &&
                      !(regwrite_q && (rdaddr_q == bus.alloc_addr_i));
   assign wr_err    = accept && (win.addr != '0) && !busy_q[win.addr];

   always_comb begin
      regwrite_d = accept && (win.addr != '0);
      rdaddr_d   = rdaddr_q;
      rddata_d   = rddata_q;
      if (accept) begin
         rdaddr_d = win.addr;
         rddata_d = win.data;
      end

      // Clear before set so a new allocation outlives the retiring write.
      busy_d = busy_q;
      if (regwrite_q) begin
         busy_d[rdaddr_q] = 1'b0;
      end
      if (bus.alloc_valid_i) begin
         busy_d[bus.alloc_addr_i] = 1'b1;
      end
      busy_d[0] = 1'b0;

      err_d = err_q | alloc_err | wr_err;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         regwrite_q <= 1'b0;
         rdaddr_q   <= '0;
         rddata_q   <= '0;
         busy_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         regwrite_q <= regwrite_d;
         rdaddr_q   <= rdaddr_d;
         rddata_q   <= rddata_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign bus.RegWrite_o = regwrite_q;
   assign bus.RDaddr_o   = rdaddr_q;
   assign bus.RDdata_o   = rddata_q;
   assign bus.err_o      = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, single write, r0, contention,
// same-edge set/clear, error flag and mid-operation reset scenarios.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alloc_valid_i = 1'b0;
      bus.alloc_addr_i  = '0;
      bus.alu_valid_i   = 1'b0;
      bus.alu_addr_i    = '0;
      bus.alu_data_i    = '0;
      bus.mem_valid_i   = 1'b0;
      bus.mem_addr_i    = '0;
      bus.mem_data_i    = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      bus.rs_addr_i = 5'd9;
      bus.rt_addr_i = 5'd5;
      rst_i = 1'b1;
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd9;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd5; bus.alu_data_i = 32'h1111_2222;
      bus.mem_valid_i = 1'b1; bus.mem_addr_i = 5'd6; bus.mem_data_i = 32'h3333_4444;
      step();
      @(negedge clk_i);
      n_checks++;
      if (bus.alu_ready_o !== 1'b0 || bus.mem_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: alu=%b mem=%b expected 0 0", bus.alu_ready_o, bus.mem_ready_o);
      end
      step();
      n_checks++;
      if (bus.RegWrite_o !== 1'b0 || bus.RDaddr_o !== 5'd0 || bus.RDdata_o !== 32'd0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: we=%b addr=%0d data=%h err=%b expected 0 0 0 0",
                  bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.err_o);
      end
      n_checks++;
      if (bus.rs_busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_busy: rs_busy(9)=%b expected 0", bus.rs_busy_o);
      end
      idle_inputs();
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_single_write();
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd5;
      bus.rs_addr_i = 5'd5;
      @(negedge clk_i);
      n_checks++;
      if (bus.rs_busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_busy_pre: rs_busy(5)=%b expected 0", bus.rs_busy_o);
      end
      step();
      bus.alloc_valid_i = 1'b0;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd5; bus.alu_data_i = 32'hDEAD_BEEF;
      @(negedge clk_i);
      n_checks++;
      if (bus.rs_busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy_set: rs_busy(5)=%b expected 1", bus.rs_busy_o);
      end
      n_checks++;
      if (bus.alu_ready_o !== 1'b1 || bus.mem_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_ready: alu=%b mem=%b expected 1 0", bus.alu_ready_o, bus.mem_ready_o);
      end
      step();
      bus.alu_valid_i = 1'b0;
      n_checks++;
      if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd5 || bus.RDdata_o !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL single_write: we=%b addr=%0d data=%h expected 1 5 deadbeef",
                  bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o);
      end
      n_checks++;
      if (bus.rs_busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL single_busy_hold: rs_busy(5)=%b expected 1", bus.rs_busy_o);
      end
      step();
      n_checks++;
      if (bus.RegWrite_o !== 1'b0 || bus.RDaddr_o !== 5'd5 || bus.rs_busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_after: we=%b addr=%0d rs_busy=%b err=%b expected 0 5 0 0",
                  bus.RegWrite_o, bus.RDaddr_o, bus.rs_busy_o, bus.err_o);
      end
   endtask

   task automatic test_r0();
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd0;
      bus.mem_valid_i = 1'b1; bus.mem_addr_i = 5'd0; bus.mem_data_i = 32'h0000_0055;
      bus.rs_addr_i = 5'd0;
      @(negedge clk_i);
      n_checks++;
      if (bus.mem_ready_o !== 1'b1 || bus.alu_ready_o !== 1'b0 || bus.rd_busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL r0_ready: mem=%b alu=%b rd_busy=%b expected 1 0 0",
                  bus.mem_ready_o, bus.alu_ready_o, bus.rd_busy_o);
      end
      step();
      idle_inputs();
      n_checks++;
      if (bus.RegWrite_o !== 1'b0 || bus.rs_busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL r0_write: we=%b rs_busy=%b err=%b expected 0 0 0",
                  bus.RegWrite_o, bus.rs_busy_o, bus.err_o);
      end
      step();
   endtask

   task automatic test_contention();
      logic [4:0] alu_regs [4] = '{5'd1, 5'd2, 5'd3, 5'd4};
      logic [4:0] mem_regs [4] = '{5'd8, 5'd9, 5'd10, 5'd11};
      // Expected winner each cycle: ALU first, then strictly alternating.
      logic       exp_mem  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int a = 0;
      int m = 0;
      for (int i = 0; i < 4; i++) begin
         bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = alu_regs[i];
         step();
         bus.alloc_addr_i = mem_regs[i];
         step();
      end
      bus.alloc_valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         logic [4:0]  exp_addr;
         logic [31:0] exp_data;
         bus.alu_valid_i = (a < 4);
         bus.alu_addr_i  = (a < 4) ? alu_regs[a] : 5'd0;
         bus.alu_data_i  = 32'h100 + a;
         bus.mem_valid_i = (m < 4);
         bus.mem_addr_i  = (m < 4) ? mem_regs[m] : 5'd0;
         bus.mem_data_i  = 32'h200 + m;
         @(negedge clk_i);
         n_checks++;
         if (bus.alu_ready_o !== !exp_mem[i] || bus.mem_ready_o !== exp_mem[i]) begin
            n_fail++;
            $display("FAIL contention_grant[%0d]: alu=%b mem=%b expected %b %b",
                     i, bus.alu_ready_o, bus.mem_ready_o, !exp_mem[i], exp_mem[i]);
         end
         if (exp_mem[i]) begin
            exp_addr = mem_regs[m]; exp_data = 32'h200 + m; m++;
         end else begin
            exp_addr = alu_regs[a]; exp_data = 32'h100 + a; a++;
         end
         step();
         n_checks++;
         if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== exp_addr || bus.RDdata_o !== exp_data) begin
            n_fail++;
            $display("FAIL contention_write[%0d]: we=%b addr=%0d data=%h expected 1 %0d %h",
                     i, bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, exp_addr, exp_data);
         end
      end
      idle_inputs();
      bus.rs_addr_i = 5'd4;
      bus.rt_addr_i = 5'd11;
      step();
      n_checks++;
      if (bus.RegWrite_o !== 1'b0 || bus.rs_busy_o !== 1'b0 || bus.rt_busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL contention_drain: we=%b rs_busy=%b rt_busy=%b err=%b expected 0 0 0 0",
                  bus.RegWrite_o, bus.rs_busy_o, bus.rt_busy_o, bus.err_o);
      end
   endtask

   task automatic test_same_edge();
      bus.rs_addr_i = 5'd7;
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd7;
      step();
      bus.alloc_valid_i = 1'b0;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd7; bus.alu_data_i = 32'h0000_0777;
      step();
      bus.alu_valid_i = 1'b0;
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd7;
      n_checks++;
      if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd7) begin
         n_fail++;
         $display("FAIL same_edge_write: we=%b addr=%0d expected 1 7", bus.RegWrite_o, bus.RDaddr_o);
      end
      step();
      bus.alloc_valid_i = 1'b0;
      n_checks++;
      if (bus.rs_busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL same_edge_set: busy(7)=%b err=%b expected 1 0", bus.rs_busy_o, bus.err_o);
      end
      bus.mem_valid_i = 1'b1; bus.mem_addr_i = 5'd7; bus.mem_data_i = 32'h0000_0778;
      step();
      bus.mem_valid_i = 1'b0;
      step();
      n_checks++;
      if (bus.rs_busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL same_edge_clear: busy(7)=%b err=%b expected 0 0", bus.rs_busy_o, bus.err_o);
      end
   endtask

   task automatic test_errors();
      bus.rs_addr_i = 5'd3;
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd3;
      step();
      @(negedge clk_i);
      n_checks++;
      if (bus.rd_busy_o !== 1'b1 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL err_pre: rd_busy=%b err=%b expected 1 0", bus.rd_busy_o, bus.err_o);
      end
      step();
      bus.alloc_valid_i = 1'b0;
      n_checks++;
      if (bus.err_o !== 1'b1 || bus.rs_busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_double_alloc: err=%b busy(3)=%b expected 1 1", bus.err_o, bus.rs_busy_o);
      end
      step(); step(); step();
      n_checks++;
      if (bus.err_o !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: err=%b expected 1", bus.err_o);
      end
   endtask

   task automatic test_reset_mid();
      bus.alloc_valid_i = 1'b1; bus.alloc_addr_i = 5'd20;
      step();
      bus.alloc_addr_i = 5'd21;
      step();
      bus.alloc_valid_i = 1'b0;
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd20; bus.alu_data_i = 32'hAAAA_0020;
      bus.mem_valid_i = 1'b1; bus.mem_addr_i = 5'd21; bus.mem_data_i = 32'hBBBB_0021;
      step();
      n_checks++;
      if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd20) begin
         n_fail++;
         $display("FAIL rstmid_first: we=%b addr=%0d expected 1 20", bus.RegWrite_o, bus.RDaddr_o);
      end
      rst_i = 1'b1;
      @(negedge clk_i);
      n_checks++;
      if (bus.alu_ready_o !== 1'b0 || bus.mem_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_ready: alu=%b mem=%b expected 0 0", bus.alu_ready_o, bus.mem_ready_o);
      end
      step();
      bus.rs_addr_i = 5'd20;
      bus.rt_addr_i = 5'd21;
      #1;
      n_checks++;
      if (bus.RegWrite_o !== 1'b0 || bus.RDaddr_o !== 5'd0 || bus.RDdata_o !== 32'd0 || bus.err_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: we=%b addr=%0d data=%h err=%b expected 0 0 0 0",
                  bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, bus.err_o);
      end
      n_checks++;
      if (bus.rs_busy_o !== 1'b0 || bus.rt_busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_busy: busy(20)=%b busy(21)=%b expected 0 0", bus.rs_busy_o, bus.rt_busy_o);
      end
      bus.rs_addr_i = 5'd3;
      #1;
      n_checks++;
      if (bus.rs_busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_busy3: busy(3)=%b expected 0", bus.rs_busy_o);
      end
      idle_inputs();
      rst_i = 1'b0;
      step();
   endtask

   task automatic test_err_unalloc();
      bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd12; bus.alu_data_i = 32'h0000_0C0C;
      step();
      bus.alu_valid_i = 1'b0;
      n_checks++;
      if (bus.err_o !== 1'b1 || bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd12) begin
         n_fail++;
         $display("FAIL err_unalloc: err=%b we=%b addr=%0d expected 1 1 12",
                  bus.err_o, bus.RegWrite_o, bus.RDaddr_o);
      end
   endtask

   initial begin
      idle_inputs();
      bus.rs_addr_i = '0;
      bus.rt_addr_i = '0;
      test_reset();
      test_single_write();
      test_r0();
      test_contention();
      test_same_edge();
      test_errors();
      test_reset_mid();
      test_err_unalloc();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
